// File: rtl/flipflop_bank.sv
// Bank of NUM_CH independent storage cells. Each cell runs as a D, T, SR or JK flip-flop,
// selected per cycle, with a sticky SR-illegal flag and a saturating transition counter.
module flipflop_bank #(
  parameter int                 NUM_CH    = 4,
  parameter int                 CNT_W     = 8,
  parameter logic [NUM_CH-1:0]  RESET_VAL = {NUM_CH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic                    err_clr,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       q,
  output logic [NUM_CH-1:0]       qb,
  output logic [NUM_CH-1:0]       err,
  output logic                    any_err,
  output logic [CNT_W*NUM_CH-1:0] tcount
);

  localparam logic [1:0]       MODE_D  = 2'b00;
  localparam logic [1:0]       MODE_T  = 2'b01;
  localparam logic [1:0]       MODE_SR = 2'b10;
  localparam logic [1:0]       MODE_JK = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]       q_n_s;
  logic [NUM_CH-1:0]       err_n_s;
  logic [CNT_W*NUM_CH-1:0] cnt_n_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       ch_mode_s;
    logic [1:0]       ab_s;
    logic             nxt_s;
    logic             illegal_s;
    logic             q_nx_s;
    logic             err_nx_s;
    logic [CNT_W-1:0] cnt_cur_s;
    logic [CNT_W-1:0] cnt_nx_s;

    assign ch_mode_s = mode[2*i +: 2];
    assign ab_s      = {a[i], b[i]};
    assign cnt_cur_s = tcount[CNT_W*i +: CNT_W];

    // Ungated next value of the cell; SR 11 holds and raises illegal instead of going X.
    always_comb begin
      nxt_s     = q[i];
      illegal_s = 1'b0;
      case (ch_mode_s)
        MODE_D:  nxt_s = a[i];
        MODE_T:  nxt_s = q[i] ^ a[i];
        MODE_SR: begin
          case (ab_s)
            2'b01:   nxt_s = 1'b0;
            2'b10:   nxt_s = 1'b1;
            2'b11:   illegal_s = 1'b1;
            default: nxt_s = q[i];
          endcase
        end
        MODE_JK: begin
          case (ab_s)
            2'b01:   nxt_s = 1'b0;
            2'b10:   nxt_s = 1'b1;
            2'b11:   nxt_s = ~q[i];
            default: nxt_s = q[i];
          endcase
        end
        default: nxt_s = q[i];
      endcase
    end

    // Enable gating; error set beats clear, counter clear beats increment.
    always_comb begin
      q_nx_s   = q[i];
      err_nx_s = err[i];
      cnt_nx_s = cnt_cur_s;
      if (en[i]) begin
        q_nx_s = nxt_s;
      end else begin
        q_nx_s = q[i];
      end
      if (en[i] && illegal_s) begin
        err_nx_s = 1'b1;
      end else if (err_clr) begin
        err_nx_s = 1'b0;
      end else begin
        err_nx_s = err[i];
      end
      if (cnt_clr) begin
        cnt_nx_s = {CNT_W{1'b0}};
      end else if (en[i] && (nxt_s != q[i]) && (cnt_cur_s != CNT_MAX)) begin
        cnt_nx_s = cnt_cur_s + CNT_ONE;
      end else begin
        cnt_nx_s = cnt_cur_s;
      end
    end

    assign q_n_s[i]                   = q_nx_s;
    assign err_n_s[i]                 = err_nx_s;
    assign cnt_n_s[CNT_W*i +: CNT_W]  = cnt_nx_s;
  end

  // qb and any_err are registered from the same next-state values so they never skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      qb      <= ~RESET_VAL;
      err     <= {NUM_CH{1'b0}};
      any_err <= 1'b0;
      tcount  <= {(CNT_W*NUM_CH){1'b0}};
    end else begin
      q       <= q_n_s;
      qb      <= ~q_n_s;
      err     <= err_n_s;
      any_err <= |err_n_s;
      tcount  <= cnt_n_s;
    end
  end

endmodule

// File: tb/tb_flipflop_bank.sv
// Self-checking bench for flipflop_bank: hand-derived vector table, then a model-driven random phase.
module tb_flipflop_bank;

  localparam int         N  = 4;
  localparam int         W  = 2;
  localparam logic [3:0] RV = 4'b1010;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic [7:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       err_clr;
  logic       cnt_clr;
  logic [3:0] q;
  logic [3:0] qb;
  logic [3:0] err;
  logic       any_err;
  logic [7:0] tcount;

  flipflop_bank #(.NUM_CH(N), .CNT_W(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .q(q), .qb(qb), .err(err),
    .any_err(any_err), .tcount(tcount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] en;
    logic [7:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       ec;
    logic       cc;
    logic [3:0] eq;
    logic [3:0] eerr;
    logic [7:0] ecnt;
  } vec_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  q;
    logic [3:0]  err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[64];
  int         nv = 0;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] last_q;
  logic       have_last = 1'b0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, tag, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] en_v, input logic [7:0] md,
                     input logic [3:0] av, input logic [3:0] bv, input logic ec, input logic cc,
                     input logic [3:0] eq, input logic [3:0] eerr, input logic [7:0] ecnt);
    tbl[nv] = '{rst, en_v, md, av, bv, ec, cc, eq, eerr, ecnt};
    nv++;
  endtask

  task automatic step(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    reset   = v.rst;
    en      = v.en;
    mode    = v.mode;
    a       = v.a;
    b       = v.b;
    err_clr = v.ec;
    cnt_clr = v.cc;
    e.tag   = tag[15:0];
    e.q     = v.eq;
    e.err   = v.eerr;
    e.cnt   = v.ecnt;
    sb.push_back(e);
    #1;
    if (have_last) chk("q_before_edge", tag, {28'd0, q}, {28'd0, last_q});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", tag, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("q", int'(e.tag), {28'd0, q}, {28'd0, e.q});
      chk("qb", int'(e.tag), {28'd0, qb}, {28'd0, ~e.q});
      chk("err", int'(e.tag), {28'd0, err}, {28'd0, e.err});
      chk("any_err", int'(e.tag), {31'd0, any_err}, {31'd0, |e.err});
      chk("tcount", int'(e.tag), {24'd0, tcount}, {24'd0, e.cnt});
      last_q    = e.q;
      have_last = 1'b1;
    end
  endtask

  logic [3:0] m_q;
  logic [3:0] m_err;
  logic [1:0] m_cnt [4];

  initial begin
    vec_t v;
    // rst en mode a b ec cc | q err tcount
    add(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h00);
    add(1'b0, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h01);
    add(1'b0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h03);
    add(1'b0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1011, 4'b0000, 8'h00);
    add(1'b0, 4'b0001, 8'h02, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h01);
    add(1'b0, 4'b0001, 8'h02, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h02, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h02, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b1010, 4'b0000, 8'h00);
    add(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h01);
    add(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h03, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h02);
    add(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 8'h03);
    add(1'b0, 4'b0001, 8'h03, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h03);
    // SR illegal on ch2, then set-vs-clear priority
    add(1'b0, 4'b0100, 8'h20, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b1110, 4'b0000, 8'h00);
    add(1'b0, 4'b0100, 8'h20, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b1110, 4'b0100, 8'h00);
    add(1'b0, 4'b0100, 8'h20, 4'b0100, 4'b0100, 1'b1, 1'b0, 4'b1110, 4'b0100, 8'h00);
    add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1110, 4'b0000, 8'h00);
    add(1'b0, 4'b0000, 8'h20, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b1110, 4'b0000, 8'h00);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'b0000, 8'h00, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1110, 4'b0000, 8'h00);
    add(1'b0, 4'b0001, 8'h00, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'h01);
    add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 8'h00);
    // ch1 T-mode saturation at 3, then clear racing a toggle
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 8'h04);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'h08);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 8'h0C);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'h0C);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 8'h0C);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8'h0C);
    add(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0000, 8'h00);
    // reset in the middle of JK toggling with err[2] set
    add(1'b0, 4'b0100, 8'h20, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b1101, 4'b0100, 8'h00);
    add(1'b0, 4'b1111, 8'hFF, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 4'b0100, 8'h55);
    add(1'b0, 4'b1111, 8'hFF, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1101, 4'b0100, 8'hAA);
    add(1'b1, 4'b1111, 8'hFF, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1010, 4'b0000, 8'h00);
    add(1'b0, 4'b1111, 8'hFF, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0101, 4'b0000, 8'h55);

    for (int k = 0; k < nv; k++) step(tbl[k], k);

    // Random phase against an independent behavioural model, seeded from the table's end state.
    m_q   = 4'b0101;
    m_err = 4'b0000;
    for (int c = 0; c < 4; c++) m_cnt[c] = 2'd1;
    for (int k = 0; k < 300; k++) begin
      v.rst  = ($urandom_range(0, 24) == 0);
      v.en   = 4'($urandom());
      v.mode = 8'($urandom());
      v.a    = 4'($urandom());
      v.b    = 4'($urandom());
      v.ec   = ($urandom_range(0, 7) == 0);
      v.cc   = ($urandom_range(0, 9) == 0);
      if (v.rst) begin
        m_q   = RV;
        m_err = 4'b0000;
        for (int c = 0; c < 4; c++) m_cnt[c] = 2'd0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          logic [1:0] md;
          logic       s, r, nxt;
          md  = v.mode[2*c +: 2];
          s   = v.a[c];
          r   = v.b[c];
          nxt = m_q[c];
          if (v.en[c]) begin
            if (md == 2'd0)      nxt = s;
            else if (md == 2'd1) nxt = s ? ~m_q[c] : m_q[c];
            else if (s && !r)    nxt = 1'b1;
            else if (!s && r)    nxt = 1'b0;
            else if (s && r && md == 2'd3) nxt = ~m_q[c];
          end
          if (v.en[c] && md == 2'd2 && s && r) m_err[c] = 1'b1;
          else if (v.ec)                       m_err[c] = 1'b0;
          if (v.cc)                                       m_cnt[c] = 2'd0;
          else if (nxt != m_q[c] && m_cnt[c] != 2'd3)     m_cnt[c] = m_cnt[c] + 2'd1;
          m_q[c] = nxt;
        end
      end
      v.eq   = m_q;
      v.eerr = m_err;
      v.ecnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
      step(v, 1000 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog step=0 got=timeout want=finish");
    $fatal(1);
  end

endmodule
